// File: rtl/alu_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_collector
// Description : Staging stage in front of the ALU core. Collects operands
//               that arrive separately and holds a partial operation until
//               the missing operand arrives or a timeout expires. It then
//               issues one registered operation with a single-cycle
//               out_valid pulse and flags timeout and illegal commands.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] in_opa,
    input  logic [DATA_WIDTH-1:0] in_opb,
    input  logic                  in_mode,
    input  logic [CMD_WIDTH-1:0]  in_cmd,
    input  logic                  in_cin,
    input  logic [1:0]            in_inp_valid,
    output logic [DATA_WIDTH-1:0] out_opa,
    output logic [DATA_WIDTH-1:0] out_opb,
    output logic                  out_mode,
    output logic [CMD_WIDTH-1:0]  out_cmd,
    output logic                  out_cin,
    output logic [1:0]            out_inp_valid,
    output logic                  out_valid,
    output logic                  out_err,
    output logic                  busy
);

    // Wide enough to hold TIMEOUT itself, so the counter never wraps.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Partial operation held while waiting for the missing operand.
    logic [DATA_WIDTH-1:0]   h_opa_q, h_opa_d;
    logic [DATA_WIDTH-1:0]   h_opb_q, h_opb_d;
    logic                    h_mode_q, h_mode_d;
    logic [CMD_WIDTH-1:0]    h_cmd_q, h_cmd_d;
    logic                    h_cin_q, h_cin_d;
    logic [1:0]              h_iv_q, h_iv_d;

    // Registered view presented to the ALU core.
    logic [DATA_WIDTH-1:0]   out_opa_q, out_opa_d;
    logic [DATA_WIDTH-1:0]   out_opb_q, out_opb_d;
    logic                    out_mode_q, out_mode_d;
    logic [CMD_WIDTH-1:0]    out_cmd_q, out_cmd_d;
    logic                    out_cin_q, out_cin_d;
    logic [1:0]              out_iv_q, out_iv_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_err_q, out_err_d;

    logic [2:0]              w_dec;
    logic                    w_illegal;
    logic [1:0]              w_need;
    logic                    w_arrive;

    // Returns {illegal, need_mask} for a mode/command pair.
    function automatic logic [2:0] decode_need(input logic mode,
                                               input logic [CMD_WIDTH-1:0] cmd);
        logic [31:0] c;
        logic [2:0]  r;
        c = 32'(cmd);
        r = 3'b100;
        if (mode) begin
            case (c)
                0, 1, 2, 3, 8, 9, 10: r = 3'b011;
                4, 5:                 r = 3'b001;
                6, 7:                 r = 3'b010;
                default:              r = 3'b100;
            endcase
        end else begin
            case (c)
                0, 1, 2, 3, 4, 5, 12, 13: r = 3'b011;
                6, 8, 9:                  r = 3'b001;
                7, 10, 11:                r = 3'b010;
                default:                  r = 3'b100;
            endcase
        end
        return r;
    endfunction

    assign w_dec     = decode_need(in_mode, in_cmd);
    assign w_illegal = w_dec[2];
    assign w_need    = w_dec[1:0];
    // The held mask has exactly one bit set, so any overlap with its
    // complement means the missing operand is on the bus.
    assign w_arrive  = |(in_inp_valid & ~h_iv_q);

    // Next-state, capture and issue decisions; everything holds when ce=0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        h_opa_d     = h_opa_q;
        h_opb_d     = h_opb_q;
        h_mode_d    = h_mode_q;
        h_cmd_d     = h_cmd_q;
        h_cin_d     = h_cin_q;
        h_iv_d      = h_iv_q;
        out_opa_d   = out_opa_q;
        out_opb_d   = out_opb_q;
        out_mode_d  = out_mode_q;
        out_cmd_d   = out_cmd_q;
        out_cin_d   = out_cin_q;
        out_iv_d    = out_iv_q;
        out_err_d   = out_err_q;
        out_valid_d = 1'b0;

        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (in_inp_valid != 2'b00) begin
                        if (w_illegal || ((in_inp_valid & w_need) == w_need)) begin
                            out_opa_d   = in_opa;
                            out_opb_d   = in_opb;
                            out_mode_d  = in_mode;
                            out_cmd_d   = in_cmd;
                            out_cin_d   = in_cin;
                            out_iv_d    = in_inp_valid;
                            out_err_d   = w_illegal;
                            out_valid_d = 1'b1;
                        end else if (w_need == 2'b11) begin
                            h_opa_d  = in_opa;
                            h_opb_d  = in_opb;
                            h_mode_d = in_mode;
                            h_cmd_d  = in_cmd;
                            h_cin_d  = in_cin;
                            h_iv_d   = in_inp_valid;
                            cnt_d    = '0;
                            state_d  = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_arrive) begin
                        // Only the missing field is taken from the bus.
                        out_opa_d   = h_iv_q[0] ? h_opa_q : in_opa;
                        out_opb_d   = h_iv_q[1] ? h_opb_q : in_opb;
                        out_mode_d  = h_mode_q;
                        out_cmd_d   = h_cmd_q;
                        out_cin_d   = h_cin_q;
                        out_iv_d    = 2'b11;
                        out_err_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (cnt_q == C_CNT_LAST) begin
                        out_opa_d   = h_opa_q;
                        out_opb_d   = h_opb_q;
                        out_mode_d  = h_mode_q;
                        out_cmd_d   = h_cmd_q;
                        out_cin_d   = h_cin_q;
                        out_iv_d    = h_iv_q;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counter, held operation and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            h_opa_q     <= '0;
            h_opb_q     <= '0;
            h_mode_q    <= 1'b0;
            h_cmd_q     <= '0;
            h_cin_q     <= 1'b0;
            h_iv_q      <= 2'b00;
            out_opa_q   <= '0;
            out_opb_q   <= '0;
            out_mode_q  <= 1'b0;
            out_cmd_q   <= '0;
            out_cin_q   <= 1'b0;
            out_iv_q    <= 2'b00;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            h_opa_q     <= h_opa_d;
            h_opb_q     <= h_opb_d;
            h_mode_q    <= h_mode_d;
            h_cmd_q     <= h_cmd_d;
            h_cin_q     <= h_cin_d;
            h_iv_q      <= h_iv_d;
            out_opa_q   <= out_opa_d;
            out_opb_q   <= out_opb_d;
            out_mode_q  <= out_mode_d;
            out_cmd_q   <= out_cmd_d;
            out_cin_q   <= out_cin_d;
            out_iv_q    <= out_iv_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_opa       = out_opa_q;
    assign out_opb       = out_opb_q;
    assign out_mode      = out_mode_q;
    assign out_cmd       = out_cmd_q;
    assign out_cin       = out_cin_q;
    assign out_inp_valid = out_iv_q;
    assign out_valid     = out_valid_q;
    assign out_err       = out_err_q;
    assign busy          = (state_q == S_WAIT);

endmodule
`default_nettype wire
